// File: rtl/mem_pkg.sv
// Shared types and helpers for the TCDM bank-side controller.
package mem_pkg;

  // Tag that travels alongside an SRAM access until its response is due
  typedef struct packed {
    logic valid;
    logic is_read;
    logic suppress;
  } tcdm_rsp_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RMW_WAIT,
    RMW_WRITE
  } bank_ctrl_state_e;

  // Byte merge for read-modify-write: enabled bytes take the new data,
  // the rest keep what the SRAM currently holds
  function automatic logic [7:0] merge_byte(input logic       be,
                                            input logic [7:0] wbyte,
                                            input logic [7:0] rbyte);
    return be ? wbyte : rbyte;
  endfunction

endpackage

// File: rtl/tcdm_rsp_pipe.sv
// Fixed-depth shift pipeline that delays response tags by the SRAM read latency.
module tcdm_rsp_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     in_i,
  output T     out_o
);

  T stage_q [DEPTH];
  T stage_d [DEPTH];

  // Shift every cycle: new tag enters stage 0, the tail leaves at DEPTH-1
  always_comb begin
    stage_d[0] = in_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers, cleared synchronously so no stale response survives a reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tcdm_bank_ctrl.sv
// Bank-side TCDM stage: turns crossbar requests into single-port SRAM accesses,
// returns in-order responses after the SRAM latency, and optionally emulates
// byte enables with read-modify-write.
module tcdm_bank_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned NUM_WORDS    = 1024,
  parameter int unsigned SRAM_LATENCY = 1,
  parameter int unsigned RMW_EN       = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic                         we_i,
  input  logic [BE_WIDTH-1:0]          be_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic                         r_valid_o,
  output logic [DATA_WIDTH-1:0]        r_rdata_o,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
  output logic [BE_WIDTH-1:0]          sram_be_o,
  output logic [DATA_WIDTH-1:0]        sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]        sram_rdata_i
);

  localparam int unsigned IDX_W    = $clog2(NUM_WORDS);
  localparam int unsigned BYTE_OFF = $clog2(BE_WIDTH) + $clog2(NUM_BANKS);
  localparam int unsigned CNT_W    = $clog2(SRAM_LATENCY + 1);
  // RMW_WAIT lasts SRAM_LATENCY-1 cycles; the counter is loaded with one less
  // because the exit is taken on the cycle it reads zero
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (SRAM_LATENCY > 1) ? CNT_W'(SRAM_LATENCY - 2) : '0;

  bank_ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      rmw_addr_q, rmw_addr_d;
  logic [BE_WIDTH-1:0]   rmw_be_q, rmw_be_d;
  logic [DATA_WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;

  logic [IDX_W-1:0]      word_idx;
  logic                  rmw_start;
  logic [DATA_WIDTH-1:0] merged;
  logic                  rmw_rsp;
  tcdm_rsp_tag_t         tag_in, tag_out;
  logic                  unused_addr;

  // Bank-select and byte-offset bits sit below the word index; anything above wraps
  assign word_idx    = addr_i[BYTE_OFF +: IDX_W];
  assign unused_addr = ^addr_i;
  assign rmw_start   = (RMW_EN != 0) && we_i && (be_i != {BE_WIDTH{1'b1}});

  // Merge the latched write data over the word that the RMW read returned
  always_comb begin
    merged = '0;
    for (int b = 0; b < int'(BE_WIDTH); b++) begin
      merged[8*b +: 8] = merge_byte(rmw_be_q[b], rmw_wdata_q[8*b +: 8],
                                    sram_rdata_i[8*b +: 8]);
    end
  end

  // Next-state and SRAM drive; everything stays quiet while reset is asserted
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_be_d     = rmw_be_q;
    rmw_wdata_d  = rmw_wdata_q;
    gnt_o        = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    tag_in       = '0;
    rmw_rsp      = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          gnt_o = req_i;
          if (req_i) begin
            sram_req_o     = 1'b1;
            sram_addr_o    = word_idx;
            tag_in.valid   = 1'b1;
            tag_in.is_read = !we_i;
            if (rmw_start) begin
              sram_be_o       = '1;
              tag_in.suppress = 1'b1;
              rmw_addr_d      = word_idx;
              rmw_be_d        = be_i;
              rmw_wdata_d     = wdata_i;
              cnt_d           = WAIT_LOAD;
              state_d         = (SRAM_LATENCY == 1) ? RMW_WRITE : RMW_WAIT;
            end else begin
              sram_we_o    = we_i;
              sram_be_o    = (RMW_EN != 0) ? {BE_WIDTH{1'b1}} : be_i;
              sram_wdata_o = wdata_i;
            end
          end
        end
        RMW_WAIT: begin
          if (cnt_q == '0) begin
            state_d = RMW_WRITE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RMW_WRITE: begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = rmw_addr_q;
          sram_be_o    = '1;
          sram_wdata_o = merged;
          rmw_rsp      = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  tcdm_rsp_pipe #(
    .DEPTH (SRAM_LATENCY),
    .T     (tcdm_rsp_tag_t)
  ) u_rsp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (tag_in),
    .out_o (tag_out)
  );

  // Response mux: pipeline tail for plain accesses, FSM for the RMW write
  always_comb begin
    r_valid_o = 1'b0;
    r_rdata_o = '0;
    if (!rst_i) begin
      r_valid_o = rmw_rsp || (tag_out.valid && !tag_out.suppress);
      if (tag_out.valid && !tag_out.suppress && tag_out.is_read) begin
        r_rdata_o = sram_rdata_i;
      end
    end
  end

  // State and RMW context registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_ctrl.sv
// Bench for tcdm_bank_ctrl: two instances (latency 1 without RMW, latency 2
// with RMW) share one stimulus stream; each has its own SRAM model and an
// transaction-level expectation model based on cycle-indexed response slots.
module tb_tcdm_bank_ctrl;

  localparam int NW = 16;

  logic        clk;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic        gnt [2];
  logic        rv [2];
  logic        sreq [2];
  logic        swe [2];
  logic [3:0]  saddr [2];
  logic [3:0]  sbe [2];
  logic [31:0] rdata [2];
  logic [31:0] swdata [2];
  logic [31:0] srdata [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  tcdm_bank_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_BANKS(2), .NUM_WORDS(NW),
    .SRAM_LATENCY(1), .RMW_EN(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[0]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .r_valid_o(rv[0]), .r_rdata_o(rdata[0]),
    .sram_req_o(sreq[0]), .sram_we_o(swe[0]), .sram_addr_o(saddr[0]),
    .sram_be_o(sbe[0]), .sram_wdata_o(swdata[0]), .sram_rdata_i(srdata[0])
  );

  tcdm_bank_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_BANKS(2), .NUM_WORDS(NW),
    .SRAM_LATENCY(2), .RMW_EN(1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[1]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .r_valid_o(rv[1]), .r_rdata_o(rdata[1]),
    .sram_req_o(sreq[1]), .sram_we_o(swe[1]), .sram_addr_o(saddr[1]),
    .sram_be_o(sbe[1]), .sram_wdata_o(swdata[1]), .sram_rdata_i(srdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macros: byte-enabled write, read data delayed by the instance latency
  logic [31:0] smem [2][NW] = '{default: '0};
  logic [31:0] spipe [2][2] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      spipe[i][1] <= spipe[i][0];
      spipe[i][0] <= (sreq[i] && !swe[i]) ? smem[i][saddr[i]] : 32'hBAD0_BAD0;
      if (sreq[i] && swe[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (sbe[i][b]) smem[i][saddr[i]][8*b +: 8] <= swdata[i][8*b +: 8];
        end
      end
    end
  end

  assign srdata[0] = spipe[0][0];
  assign srdata[1] = spipe[1][1];

  // Expectation model: word contents, lock-out window, and per-cycle slots
  logic [31:0] mmem [2][NW];
  int          busy_until [2];
  logic        slot_v [2][8];
  logic [31:0] slot_d [2][8];
  logic        slot_wr [2][8];
  logic [31:0] slot_wd [2][8];
  logic [3:0]  slot_wbe [2][8];
  int          slot_wa [2][8];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic rmw_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [31:0] bemask(input logic [3:0] b);
    logic [31:0] m;
    m = 32'h0;
    if (b[0]) m = m | 32'h0000_00FF;
    if (b[1]) m = m | 32'h0000_FF00;
    if (b[2]) m = m | 32'h00FF_0000;
    if (b[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input int inst,
                             input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s[dut%0d] cycle %0d: observed %h expected %h",
             tag, inst, cyc, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model
  task automatic step();
    int          s, ns, w;
    logic        eg, part;
    logic [31:0] m, mv;
    #1;
    s = cyc % 8;
    w = int'((addr >> 3) % NW);
    for (int i = 0; i < 2; i++) begin
      eg = req && !rst && (cyc > busy_until[i]);
      checkOutput("gnt", i, 32'(gnt[i]), 32'(eg));
      if (rst) begin
        checkOutput("rvalid_in_reset", i, 32'(rv[i]), 32'd0);
        checkOutput("sreq_in_reset", i, 32'(sreq[i]), 32'd0);
        for (int k = 0; k < 8; k++) begin
          slot_v[i][k]  = 1'b0;
          slot_wr[i][k] = 1'b0;
        end
        busy_until[i] = -1;
      end else begin
        checkOutput("rvalid", i, 32'(rv[i]), 32'(slot_v[i][s]));
        if (slot_v[i][s]) checkOutput("rdata", i, rdata[i], slot_d[i][s]);
        if (slot_wr[i][s]) begin
          m  = bemask(slot_wbe[i][s]);
          mv = (slot_wd[i][s] & m) | (mmem[i][slot_wa[i][s]] & ~m);
          checkOutput("rmw_sreq", i, 32'(sreq[i]), 32'd1);
          checkOutput("rmw_swe", i, 32'(swe[i]), 32'd1);
          checkOutput("rmw_saddr", i, 32'(saddr[i]), 32'(slot_wa[i][s]));
          checkOutput("rmw_sbe", i, 32'(sbe[i]), 32'hF);
          checkOutput("rmw_swdata", i, swdata[i], mv);
          mmem[i][slot_wa[i][s]] = mv;
        end else if (eg) begin
          part = rmw_of(i) && we && (be != 4'hF);
          checkOutput("sreq", i, 32'(sreq[i]), 32'd1);
          checkOutput("saddr", i, 32'(saddr[i]), 32'(w));
          checkOutput("swe", i, 32'(swe[i]), 32'(we && !part));
          checkOutput("sbe", i, 32'(sbe[i]), rmw_of(i) ? 32'hF : 32'(be));
          ns = (cyc + lat_of(i)) % 8;
          slot_v[i][ns]  = 1'b1;
          slot_d[i][ns]  = we ? 32'h0 : mmem[i][w];
          slot_wr[i][ns] = part;
          if (part) begin
            slot_wd[i][ns]  = wdata;
            slot_wbe[i][ns] = be;
            slot_wa[i][ns]  = w;
            busy_until[i]   = cyc + lat_of(i);
          end else if (we) begin
            checkOutput("swdata", i, swdata[i], wdata);
            m = bemask(be);
            mmem[i][w] = (wdata & m) | (mmem[i][w] & ~m);
          end
        end else begin
          checkOutput("sreq_idle", i, 32'(sreq[i]), 32'd0);
        end
        slot_v[i][s]  = 1'b0;
        slot_wr[i][s] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic q, input logic w_en,
                               input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
    rst   = r;
    req   = q;
    we    = w_en;
    addr  = a;
    be    = b;
    wdata = d;
    step();
  endtask

  function automatic logic [31:0] word_addr(input int w);
    return 32'(w) << 3;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      busy_until[i] = -1;
      for (int k = 0; k < NW; k++) mmem[i][k] = 32'h0;
      for (int k = 0; k < 8; k++) begin
        slot_v[i][k]   = 1'b0;
        slot_d[i][k]   = 32'h0;
        slot_wr[i][k]  = 1'b0;
        slot_wd[i][k]  = 32'h0;
        slot_wbe[i][k] = 4'h0;
        slot_wa[i][k]  = 0;
      end
    end

    // Reset while a request is pending: no grant, no response, no SRAM strobe
    applyStimulus(1, 1, 0, word_addr(2), 4'hF, 0);
    applyStimulus(1, 1, 0, word_addr(2), 4'hF, 0);

    // Preload every word with a full write; the first one also checks the post-reset grant
    for (int w = 0; w < NW; w++) applyStimulus(0, 1, 1, word_addr(w), 4'hF, $urandom);

    // Write then immediately read the same word
    applyStimulus(0, 1, 1, word_addr(5), 4'hF, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, word_addr(5), 4'hF, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 4'h0, 0);

    // Back-to-back reads of words 0..3
    for (int w = 0; w < 4; w++) applyStimulus(0, 1, 0, word_addr(w), 4'hF, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 4'h0, 0);

    // Partial write merged into a known word, request held through the lock-out
    applyStimulus(0, 1, 1, word_addr(7), 4'hF, 32'h11223344);
    applyStimulus(0, 0, 0, 0, 4'h0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, word_addr(7), 4'h5, 32'hAABBCCDD);
    applyStimulus(0, 1, 0, word_addr(7), 4'hF, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 4'h0, 0);

    // Reset lands while the RMW is waiting for its read data
    applyStimulus(0, 1, 1, word_addr(9), 4'hF, 32'h11223344);
    applyStimulus(0, 1, 1, word_addr(9), 4'h5, 32'hAABBCCDD);
    applyStimulus(1, 0, 0, 0, 4'h0, 0);
    applyStimulus(0, 1, 0, word_addr(9), 4'hF, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 4'h0, 0);

    // Word index beyond NUM_WORDS wraps; high address and byte-offset bits ignored
    applyStimulus(0, 1, 1, 32'hF000_0000 | word_addr(NW + 3) | 32'h5, 4'h6, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 0, 4'h0, 0);
    applyStimulus(0, 1, 0, word_addr(3), 4'hF, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 4'h0, 0);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75),
                    1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
                    $urandom);
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 4'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
